// File: rtl/pe_pkg.sv
// Shared definitions for the 3-term dot-product PE operand feeder:
// fill-state encoding, pair count and operand-pair layout.
package pe_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fstate_e;

    localparam int PE_PAIRS   = 3;
    localparam int PE_M_WIDTH = 8;

    typedef struct packed {
        logic [PE_M_WIDTH-1:0] a;
        logic [PE_M_WIDTH-1:0] b;
    } pe_pair_t;

    // Zero pairs a packet carries for a given number of real pairs (1..3).
    function automatic logic [1:0] pad_pairs(input logic [1:0] real_cnt);
        return 2'd3 - real_cnt;
    endfunction

endpackage

// File: rtl/pe3_feeder_outreg.sv
// Registered six-operand output stage with valid/ready hold logic.
// Optional statistics counters are built only when FEEDER_STATS_EN is defined.
module pe3_feeder_outreg
    import pe_pkg::*;
#(
    parameter int M_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [2*PE_PAIRS*M_WIDTH-1:0]    load_data,
    input  logic [1:0]                       load_cnt,
    input  logic                             out_ready,
    output logic                             out_free,
    output logic                             out_valid,
    output logic [M_WIDTH-1:0]               out00,
    output logic [M_WIDTH-1:0]               out01,
    output logic [M_WIDTH-1:0]               out10,
    output logic [M_WIDTH-1:0]               out11,
    output logic [M_WIDTH-1:0]               out20,
    output logic [M_WIDTH-1:0]               out21,
    output logic [1:0]                       out_cnt
`ifdef FEEDER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]             grp_cnt,
    output logic [CNT_WIDTH-1:0]             pad_cnt
`endif
);

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    assign out_free = !out_valid || out_ready;

    // Output registers: load a new packet or retire the current one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out00     <= '0;
            out01     <= '0;
            out10     <= '0;
            out11     <= '0;
            out20     <= '0;
            out21     <= '0;
            out_cnt   <= 2'd0;
        end else if (load) begin
            out_valid <= 1'b1;
            out00     <= load_data[0*M_WIDTH +: M_WIDTH];
            out01     <= load_data[1*M_WIDTH +: M_WIDTH];
            out10     <= load_data[2*M_WIDTH +: M_WIDTH];
            out11     <= load_data[3*M_WIDTH +: M_WIDTH];
            out20     <= load_data[4*M_WIDTH +: M_WIDTH];
            out21     <= load_data[5*M_WIDTH +: M_WIDTH];
            out_cnt   <= load_cnt;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FEEDER_STATS_EN
    // Group and padding statistics, counted on each completed output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt <= '0;
            pad_cnt <= '0;
        end else if (out_valid && out_ready) begin
            grp_cnt <= grp_cnt + CNT_WIDTH'(1);
            pad_cnt <= pad_cnt + CNT_WIDTH'(pad_pairs(out_cnt));
        end
    end
`endif

endmodule

// File: rtl/pe3_feeder.sv
// Serial-to-parallel operand packer: three a/b pairs per packet, zero-padded
// on in_last. Statistics ports exist only when FEEDER_STATS_EN is defined.
module pe3_feeder
    import pe_pkg::*;
#(
    parameter int M_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [M_WIDTH-1:0]   in_a,
    input  logic [M_WIDTH-1:0]   in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M_WIDTH-1:0]   out00,
    output logic [M_WIDTH-1:0]   out01,
    output logic [M_WIDTH-1:0]   out10,
    output logic [M_WIDTH-1:0]   out11,
    output logic [M_WIDTH-1:0]   out20,
    output logic [M_WIDTH-1:0]   out21,
    output logic [1:0]           out_cnt
`ifdef FEEDER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] grp_cnt,
    output logic [CNT_WIDTH-1:0] pad_cnt
`endif
);

    fstate_e                          state_r;
    fstate_e                          next_state_s;
    logic [1:0]                       slot_r;
    logic [1:0]                       pend_cnt_r;
    logic [M_WIDTH-1:0]               fill_a_r [PE_PAIRS];
    logic [M_WIDTH-1:0]               fill_b_r [PE_PAIRS];
    logic                             accept_s;
    logic                             close_s;
    logic                             load_s;
    logic                             out_free_s;
    logic [2*PE_PAIRS*M_WIDTH-1:0]    load_data_s;

    assign in_ready = (state_r == FILL);
    assign accept_s = in_valid && (state_r == FILL);
    assign close_s  = in_last || (slot_r == 2'd2);
    assign load_s   = (state_r == HOLD) && out_free_s;

    // Next-state logic: close a group into HOLD, release HOLD once the output frees.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FILL: begin
                if (accept_s && close_s) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = FILL;
                end
            end
            HOLD: begin
                if (out_free_s) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: next_state_s = FILL;
        endcase
    end

    // Flatten the fill buffer as {b2,a2,b1,a1,b0,a0} for the output stage.
    always_comb begin
        load_data_s = '0;
        for (int i = 0; i < PE_PAIRS; i++) begin
            load_data_s[(2*i)*M_WIDTH   +: M_WIDTH] = fill_a_r[i];
            load_data_s[(2*i+1)*M_WIDTH +: M_WIDTH] = fill_b_r[i];
        end
    end

    // State, slot pointer and fill buffer; slots past an early close are zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FILL;
            slot_r     <= 2'd0;
            pend_cnt_r <= 2'd0;
            for (int i = 0; i < PE_PAIRS; i++) begin
                fill_a_r[i] <= '0;
                fill_b_r[i] <= '0;
            end
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                for (int i = 0; i < PE_PAIRS; i++) begin
                    if (2'(i) == slot_r) begin
                        fill_a_r[i] <= in_a;
                        fill_b_r[i] <= in_b;
                    end else if (close_s && (2'(i) > slot_r)) begin
                        fill_a_r[i] <= '0;
                        fill_b_r[i] <= '0;
                    end
                end
                if (close_s) begin
                    slot_r     <= 2'd0;
                    pend_cnt_r <= slot_r + 2'd1;
                end else begin
                    slot_r <= slot_r + 2'd1;
                end
            end else if (load_s) begin
                for (int i = 0; i < PE_PAIRS; i++) begin
                    fill_a_r[i] <= '0;
                    fill_b_r[i] <= '0;
                end
            end
        end
    end

    pe3_feeder_outreg #(
        .M_WIDTH   (M_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (load_data_s),
        .load_cnt  (pend_cnt_r),
        .out_ready (out_ready),
        .out_free  (out_free_s),
        .out_valid (out_valid),
        .out00     (out00),
        .out01     (out01),
        .out10     (out10),
        .out11     (out11),
        .out20     (out20),
        .out21     (out21),
        .out_cnt   (out_cnt)
`ifdef FEEDER_STATS_EN
        ,
        .grp_cnt   (grp_cnt),
        .pad_cnt   (pad_cnt)
`endif
    );

endmodule

// File: tb/tb_pe3_feeder.sv
// Scoreboard bench for pe3_feeder: directed pair streams push expected packets,
// a negedge monitor pops and compares on every output handshake.
module tb_pe3_feeder;

    localparam int MW = 8;
    localparam int CW = 2;

    typedef struct packed {
        logic [5:0][MW-1:0] d;
        logic [1:0]         cnt;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_a;
    logic [MW-1:0] in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] out00, out01, out10, out11, out20, out21;
    logic [1:0]    out_cnt;
`ifdef FEEDER_STATS_EN
    logic [CW-1:0] grp_cnt;
    logic [CW-1:0] pad_cnt;
`endif

    pkt_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pe3_feeder #(.M_WIDTH(MW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out00     (out00),
        .out01     (out01),
        .out10     (out10),
        .out11     (out11),
        .out20     (out20),
        .out21     (out21),
        .out_cnt   (out_cnt)
`ifdef FEEDER_STATS_EN
        ,
        .grp_cnt   (grp_cnt),
        .pad_cnt   (pad_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_pkt(input logic [MW-1:0] d0, d1, d2, d3, d4, d5, input logic [1:0] c);
        pkt_t p;
        p.d   = {d5, d4, d3, d2, d1, d0};
        p.cnt = c;
        exp_q.push_back(p);
    endtask

    // Present one pair; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] cur_bus();
        return {out21, out20, out11, out10, out01, out00};
    endfunction

    // Monitor: stability under backpressure and scoreboard compare on handshake.
    initial begin
        logic [47:0] snap;
        logic [1:0]  snap_cnt;
        bit          held;
        pkt_t        e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("hold_data", cur_bus(), snap);
                    chk("hold_cnt", out_cnt, snap_cnt);
                end
                if (out_valid && !out_ready) begin
                    held     = 1'b1;
                    snap     = cur_bus();
                    snap_cnt = out_cnt;
                end else begin
                    held = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pkt", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pkt_data", cur_bus(), e.d);
                        chk("pkt_cnt", out_cnt, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_bus", cur_bus(), 48'd0);
        chk("rst_out_cnt", out_cnt, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full group, then latency: HOLD cycle, then out_valid.
        expect_pkt(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 2'd3);
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b0);
        @(negedge clk);
        chk("lat_hold_valid", out_valid, 1'b0);
        chk("lat_hold_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("lat_valid_rise", out_valid, 1'b1);
        drain();

        // Short group closed by in_last.
        expect_pkt(8'd7, 8'd8, 8'd9, 8'd10, 8'd0, 8'd0, 2'd2);
        send(8'd7, 8'd8, 1'b0);
        send(8'd9, 8'd10, 1'b1);
        drain();
`ifdef FEEDER_STATS_EN
        chk("stats_grp_2", grp_cnt, 2'd2);
        chk("stats_pad_1", pad_cnt, 2'd1);
`endif

        // Single pair closed by in_last.
        expect_pkt(8'hFF, 8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 2'd1);
        send(8'hFF, 8'h80, 1'b1);
        drain();

        // Backpressure: two groups stream in with out_ready low.
        out_ready = 1'b0;
        expect_pkt(8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 2'd3);
        expect_pkt(8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 2'd3);
        send(8'd11, 8'd12, 1'b0);
        send(8'd13, 8'd14, 1'b0);
        send(8'd15, 8'd16, 1'b0);
        send(8'd21, 8'd22, 1'b0);
        send(8'd23, 8'd24, 1'b0);
        send(8'd25, 8'd26, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out00", out00, 8'd11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_out_valid", out_valid, 1'b1);
        chk("b2b_out00", out00, 8'd21);
        drain();
        chk("after_bp_in_ready", in_ready, 1'b1);

        // Asynchronous reset in the middle of a group.
        send(8'd31, 8'd32, 1'b0);
        send(8'd33, 8'd34, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_bus", cur_bus(), 48'd0);
        chk("mid_rst_out_cnt", out_cnt, 2'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_pkt(8'd41, 8'd42, 8'd43, 8'd44, 8'd45, 8'd46, 2'd3);
        send(8'd41, 8'd42, 1'b0);
        send(8'd43, 8'd44, 1'b0);
        send(8'd45, 8'd46, 1'b0);
        drain();

        // Four more groups; in_last without in_valid must be ignored.
        expect_pkt(8'h51, 8'h52, 8'd0, 8'd0, 8'd0, 8'd0, 2'd1);
        expect_pkt(8'h53, 8'h54, 8'h55, 8'h56, 8'd0, 8'd0, 2'd2);
        expect_pkt(8'h57, 8'h58, 8'd0, 8'd0, 8'd0, 8'd0, 2'd1);
        expect_pkt(8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D, 8'h5E, 2'd3);
        send(8'h51, 8'h52, 1'b1);
        send(8'h53, 8'h54, 1'b0);
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_last = 1'b0;
        send(8'h55, 8'h56, 1'b1);
        send(8'h57, 8'h58, 1'b1);
        send(8'h59, 8'h5A, 1'b0);
        send(8'h5B, 8'h5C, 1'b0);
        send(8'h5D, 8'h5E, 1'b0);
        drain();
`ifdef FEEDER_STATS_EN
        chk("stats_grp_wrap", grp_cnt, 2'd1);
        chk("stats_pad_wrap", pad_cnt, 2'd1);
`endif

        chk("queue_empty", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
